// File: rtl/zxbus_capture.sv
// ZX-BUS cycle monitor: demultiplexes the FA address lanes, synchronises the bus
// strobes and queues one {addr, data, type} event per completed mem/IO cycle.
module zxbus_capture #(
    parameter int ADDR_W      = 16,
    parameter int SEL_W       = 1,
    parameter int FIFO_DEPTH  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [7:0]                    fa,
    input  logic [SEL_W-1:0]              fa_sel,
    input  logic [7:0]                    fd,
    input  logic                          frd_n,
    input  logic                          fwr_n,
    input  logic                          fmrq_n,
    input  logic                          fiorq_n,
    input  logic                          fm1_n,
    input  logic                          capture_en,
    input  logic [3:0]                    type_mask,
    output logic [ADDR_W-1:0]             zaddr,
    output logic                          evt_valid,
    input  logic                          evt_ready,
    output logic [ADDR_W-1:0]             evt_addr,
    output logic [7:0]                    evt_data,
    output logic [2:0]                    evt_type,
    output logic [$clog2(FIFO_DEPTH):0]   fill,
    output logic                          overflow,
    input  logic                          clr_ovf
);

    localparam int PH = ADDR_W / 8;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int FW = PW + 1;
    localparam int EW = ADDR_W + 8 + 3;

    typedef enum logic [1:0] {IDLE, ACTIVE, PUSH} state_t;

    // Address lanes: no synchroniser, the bus holds FA stable for many clocks.
    wire [ADDR_W-1:0] zaddr_w;

    genvar gi;
    generate
        for (gi = 0; gi < PH; gi++) begin : g_lane
            logic [7:0] lane_reg;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    lane_reg <= 8'h00;
                else if (fa_sel == SEL_W'(gi))
                    lane_reg <= fa;
            end
            assign zaddr_w[8*gi +: 8] = lane_reg;
        end
    endgenerate

    assign zaddr = zaddr_w;

    // Strobe bits: {m1, iorq, mrq, wr, rd}, all active low.
    logic [4:0]             strb_sync_reg [SYNC_STAGES];
    logic [7:0]             fd_sync_reg   [SYNC_STAGES];
    logic                   rd_d_reg, wr_d_reg;
    logic [7:0]             fd_d_reg;
    logic [SYNC_STAGES-1:0] warm_reg;
    logic                   armed_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                strb_sync_reg[i] <= 5'b11111;
                fd_sync_reg[i]   <= 8'h00;
            end
            rd_d_reg  <= 1'b1;
            wr_d_reg  <= 1'b1;
            fd_d_reg  <= 8'h00;
            warm_reg  <= '0;
            armed_reg <= 1'b0;
        end else begin
            strb_sync_reg[0] <= {fm1_n, fiorq_n, fmrq_n, fwr_n, frd_n};
            fd_sync_reg[0]   <= fd;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                strb_sync_reg[i] <= strb_sync_reg[i-1];
                fd_sync_reg[i]   <= fd_sync_reg[i-1];
            end
            rd_d_reg  <= strb_sync_reg[SYNC_STAGES-1][0];
            wr_d_reg  <= strb_sync_reg[SYNC_STAGES-1][1];
            fd_d_reg  <= fd_sync_reg[SYNC_STAGES-1];
            warm_reg  <= {warm_reg[SYNC_STAGES-2:0], 1'b1};
            // Only real pin samples may arm, so a strobe low at reset release is ignored.
            armed_reg <= armed_reg | (warm_reg[SYNC_STAGES-1] &
                         strb_sync_reg[SYNC_STAGES-1][0] & strb_sync_reg[SYNC_STAGES-1][1]);
        end
    end

    logic rd_s, wr_s, mrq_s, iorq_s, m1_s;
    assign rd_s   = strb_sync_reg[SYNC_STAGES-1][0];
    assign wr_s   = strb_sync_reg[SYNC_STAGES-1][1];
    assign mrq_s  = strb_sync_reg[SYNC_STAGES-1][2];
    assign iorq_s = strb_sync_reg[SYNC_STAGES-1][3];
    assign m1_s   = strb_sync_reg[SYNC_STAGES-1][4];

    logic rd_fall, wr_fall, bus_ok, mask_ok, start;
    assign rd_fall = rd_d_reg & ~rd_s;
    assign wr_fall = wr_d_reg & ~wr_s;
    // Interrupt acknowledge (IORQ with M1) is not a data cycle.
    assign bus_ok  = (~mrq_s | ~iorq_s) & ~(~iorq_s & ~m1_s);
    assign mask_ok = type_mask[{~iorq_s, wr_fall}];
    assign start   = armed_reg & capture_en & (rd_fall | wr_fall) & bus_ok & mask_ok;

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] cap_addr_reg;
    logic [7:0]        cap_data_reg;
    logic [2:0]        cap_type_reg;
    logic              data_ok_reg;
    logic              act_strb;
    logic              push_req;

    // The FSM follows the delayed strobe copy so it stays aligned with fd_d_reg.
    assign act_strb = cap_type_reg[0] ? wr_d_reg : rd_d_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        push_req   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start)
                    state_next = ACTIVE;
            end
            ACTIVE: begin
                if (act_strb) begin
                    if (data_ok_reg)
                        state_next = PUSH;
                    else if (mrq_s & iorq_s)
                        state_next = IDLE;
                end
            end
            PUSH: begin
                push_req   = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_addr_reg <= '0;
            cap_data_reg <= 8'h00;
            cap_type_reg <= 3'b000;
            data_ok_reg  <= 1'b0;
        end else begin
            if (state_reg == IDLE && start) begin
                cap_addr_reg <= zaddr_w;
                cap_type_reg <= {~m1_s, ~iorq_s, wr_fall};
                data_ok_reg  <= 1'b0;
            end else if (state_reg == ACTIVE && !act_strb) begin
                cap_data_reg <= fd_d_reg;
                data_ok_reg  <= 1'b1;
            end
        end
    end

    // Show-ahead event FIFO.
    logic [EW-1:0] fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [FW-1:0] fill_reg;
    logic          ovf_reg;
    logic          full, empty, do_pop, do_push, drop;

    assign full    = (fill_reg == FW'(FIFO_DEPTH));
    assign empty   = (fill_reg == '0);
    assign do_pop  = ~empty & evt_ready;
    assign do_push = push_req & (~full | do_pop);
    assign drop    = push_req & full & ~do_pop;

    always_ff @(posedge clk) begin
        if (do_push)
            fifo_mem[wr_ptr_reg] <= {cap_addr_reg, cap_data_reg, cap_type_reg};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            fill_reg   <= '0;
            ovf_reg    <= 1'b0;
        end else begin
            if (do_push)
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
            if (do_pop)
                rd_ptr_reg <= rd_ptr_reg + PW'(1);
            case ({do_push, do_pop})
                2'b10:   fill_reg <= fill_reg + FW'(1);
                2'b01:   fill_reg <= fill_reg - FW'(1);
                default: fill_reg <= fill_reg;
            endcase
            if (drop)
                ovf_reg <= 1'b1;
            else if (clr_ovf)
                ovf_reg <= 1'b0;
        end
    end

    logic [EW-1:0] head;
    assign head      = empty ? '0 : fifo_mem[rd_ptr_reg];
    assign evt_valid = ~empty;
    assign evt_addr  = head[EW-1 -: ADDR_W];
    assign evt_data  = head[10:3];
    assign evt_type  = head[2:0];
    assign fill      = fill_reg;
    assign overflow  = ovf_reg;

endmodule

// File: doc/zxbus_capture.md
Name: zxbus_capture

Overview:
- Parametrised ZX-BUS monitor. It demultiplexes the byte-serial FA address bus into a full-width address and synchronises the bus strobes to clk.
- It classifies completed memory and IO read/write cycles and queues one event per cycle (address, data, type) in an internal show-ahead FIFO. A debug or host engine drains the FIFO.
- Sits between the ZX-BUS pins and the on-FPGA consumers, clocked from the 100 MHz PLL output.

Parameters:
ADDR_W, 16, captured address width; must be 16, 24 or 32 (PH = ADDR_W/8 address phases)
SEL_W, 1, width of fa_sel; equals $clog2(ADDR_W/8)
FIFO_DEPTH, 16, event FIFO entries; power of two, >= 4
SYNC_STAGES, 2, synchroniser flops on strobes and data; 2..4

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
fa  in  8  multiplexed address byte
fa_sel  in  SEL_W  byte-lane select for fa (0 = bits 7:0)
fd  in  8  bus data
frd_n  in  1  RD strobe, active low
fwr_n  in  1  WR strobe, active low
fmrq_n  in  1  MREQ, active low
fiorq_n  in  1  IORQ, active low
fm1_n  in  1  M1, active low
capture_en  in  1  1 = new cycles may be captured
type_mask  in  4  enables: [0] mem rd, [1] mem wr, [2] io rd, [3] io wr
zaddr  out  ADDR_W  live demultiplexed address
evt_valid  out  1  FIFO not empty
evt_ready  in  1  consumer pop
evt_addr  out  ADDR_W  head event address
evt_data  out  8  head event data
evt_type  out  3  {m1, io, wr} of head event
fill  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy
overflow  out  1  sticky: an event was dropped
clr_ovf  in  1  clears overflow

Behaviour:
- Reset: zaddr=0, fill=0, evt_valid=0, overflow=0, FSM=IDLE, armed=0. Strobe and control synchronisers reset to 1 (inactive); fd pipeline resets to 0. evt_addr/data/type=0.
- Address lanes: each clk, zaddr[8*fa_sel +: 8] <= fa. fa_sel >= PH: no update. No synchroniser on the address path; the bus holds it stable for many clk.
- Sync: frd_n, fwr_n, fmrq_n, fiorq_n, fm1_n pass through SYNC_STAGES flops. fd passes through a SYNC_STAGES-deep register chain so it stays aligned with the strobes.
- armed: set when synced rd_n and wr_n are both 1. Result: a strobe already low at reset release produces no event.
- FSM IDLE -> ACTIVE, when all of the following hold:
  - armed=1 and capture_en=1
  - synced (rd_n or wr_n) falls
  - (mrq_n=0 or iorq_n=0)
  - the matching type_mask bit is 1
- On that transition, latch: addr = zaddr; type = {~m1_n, ~iorq_n, ~wr_n}.
  - M1 fetch counts as mem rd.
  - MREQ with no RD/WR (refresh) is ignored.
  - IORQ with M1 (interrupt ack) is ignored.
- ACTIVE: each clk, latch the aligned fd. When the synced active strobe rises -> PUSH. The data pushed is the fd value from the last cycle the strobe was low.
- ACTIVE -> IDLE without push if the synced strobe and both mrq_n/iorq_n go high together with no valid data cycle. Not expected on a legal bus.
- PUSH (1 clk): write {addr, data, type} if not full, else set overflow and drop the event. -> IDLE.
- Latency:
  - pin strobe fall -> ACTIVE: SYNC_STAGES+1 clk.
  - pin strobe rise -> evt_valid: SYNC_STAGES+3 clk when the FIFO was empty.
- capture_en=0 or a type_mask change mid-cycle: an in-progress cycle still completes and is pushed.
- FIFO: show-ahead; evt_* show the head entry; pop when evt_valid & evt_ready.
  - Pop on empty is ignored.
  - Push and pop in the same clk when full: both happen; fill is unchanged; no overflow.
  - Pointers wrap modulo FIFO_DEPTH.
- overflow: clr_ovf clears it. If clr_ovf and a drop occur in the same clk, overflow ends set (set wins).
- rst_n assertion mid-operation discards the in-flight cycle and all queued events immediately.

Test Plan:
- ADDR_W=16: fa=0x34 with fa_sel=0, then fa=0x12 with fa_sel=1; memory write of 0xA5 -> one event {0x1234, 0xA5, 3'b001}, fill=1.
- M1 opcode fetch at 0x0038 with fd=0xFF -> evt_type=3'b100, evt_data=0xFF. A following refresh MREQ with no RD produces no event.
- IO read from port 0x00FE, type_mask=4'b1011 -> no event. Same read with type_mask=4'hF -> {0x00FE, fd, 3'b010}.
- FIFO_DEPTH=4, evt_ready=0: 5 write cycles -> fill=4, overflow=1, head = first event. One pop with clr_ovf -> fill=3, overflow=0.
- FIFO full, and a 5th cycle's push coincides with a pop -> fill stays 4, overflow stays 0, order preserved.
- frd_n held low across rst_n release -> no event. Reset asserted mid-ACTIVE -> evt_valid=0, fill=0. ADDR_W=24 with fa_sel=2 writes bits 23:16.
